// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock gray-pointer FIFO.
// Pointer code conversions, depth derivation and diagnostic counter width.
package fifo_pkg;

    localparam int DROP_CNT_W   = 8;
    localparam int ADDRSIZE_DEF = 4;
    localparam int DEPTH        = 1 << ADDRSIZE_DEF;

    function automatic int depth_of(input int addrsize);
        return 1 << addrsize;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Gray to binary converter, each binary bit is the XOR of all
// gray bits at or above it.
module gray2bin #(
    parameter int SIZE = 5
) (
    input  logic [SIZE-1:0] gray,
    output logic [SIZE-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < SIZE; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer, full/almost-full, level and overflow
// diagnostics for the dual-clock gray-pointer FIFO.
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  wclk,
    input  logic                  wresetb,
    input  logic                  winc,
    input  logic [ADDRSIZE:0]     wq2_rptr,
    input  logic                  wovf_clr,
    output logic [ADDRSIZE-1:0]   waddr,
    output logic                  wclken,
    output logic [ADDRSIZE:0]     wptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDRSIZE:0]     wlevel,
    output logic                  woverflow,
    output logic [DROP_CNT_W-1:0] wdrop_cnt
);

    localparam int A = ADDRSIZE;
    localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

    logic [A:0]            wbin_q, wbin_d;
    logic [A:0]            wptr_q, wptr_d;
    logic                  wfull_q, wfull_d;
    logic                  wafull_q, wafull_d;
    logic [A:0]            wlevel_q, wlevel_d;
    logic                  wovf_q, wovf_d;
    logic [DROP_CNT_W-1:0] wdrop_q, wdrop_d;
    logic [A:0]            rbin_s;
    logic [A:0]            level_next;
    logic                  reject;

    gray2bin #(
        .SIZE(A + 1)
    ) u_rptr_g2b (
        .gray(wq2_rptr),
        .bin (rbin_s)
    );

    assign wclken = winc & ~wfull_q;
    assign waddr  = wbin_q[A-1:0];
    assign reject = winc & wfull_q;

    always_comb begin
        wbin_d     = wbin_q + {{A{1'b0}}, wclken};
        wptr_d     = (wbin_d >> 1) ^ wbin_d;
        // Full when the next write pointer is exactly one lap ahead of the read pointer
        wfull_d    = (wptr_d == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]});
        level_next = wbin_d - rbin_s;
        wlevel_d   = level_next;
        wafull_d   = (level_next >= (A+1)'(AFULL_THRESH));
    end

    // Clear takes effect before a same-cycle reject is recorded
    always_comb begin
        wovf_d  = wovf_q;
        wdrop_d = wdrop_q;
        if (wovf_clr) begin
            wovf_d  = 1'b0;
            wdrop_d = '0;
        end
        if (reject) begin
            wovf_d = 1'b1;
            if (wdrop_d != DROP_MAX) begin
                wdrop_d = wdrop_d + 1'b1;
            end
        end
    end

    always_ff @(posedge wclk or negedge wresetb) begin
        if (!wresetb) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wlevel_q <= '0;
            wovf_q   <= 1'b0;
            wdrop_q  <= '0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wlevel_q <= wlevel_d;
            wovf_q   <= wovf_d;
            wdrop_q  <= wdrop_d;
        end
    end

    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = wafull_q;
    assign wlevel       = wlevel_q;
    assign woverflow    = wovf_q;
    assign wdrop_cnt    = wdrop_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Randomized self-checking bench for wptr_full_ctrl against a
// count-based FIFO occupancy model.
module tb_wptr_full_ctrl;

    logic       wclk;
    logic       wresetb;
    logic       winc;
    logic [4:0] wq2_rptr;
    logic       wovf_clr;
    logic [3:0] waddr;
    logic       wclken;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       woverflow;
    logic [7:0] wdrop_cnt;

    wptr_full_ctrl #(
        .ADDRSIZE    (4),
        .AFULL_THRESH(12)
    ) dut (
        .wclk        (wclk),
        .wresetb     (wresetb),
        .winc        (winc),
        .wq2_rptr    (wq2_rptr),
        .wovf_clr    (wovf_clr),
        .waddr       (waddr),
        .wclken      (wclken),
        .wptr        (wptr),
        .wfull       (wfull),
        .walmost_full(walmost_full),
        .wlevel      (wlevel),
        .woverflow   (woverflow),
        .wdrop_cnt   (wdrop_cnt)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int n_chk;
    int n_pass;

    // Model: absolute counts of accepted writes and of reads seen
    int m_wr;
    int m_rd;
    int m_lvl;
    int m_drop;
    bit m_ovf;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] gray(input int b);
        logic [4:0] x;
        x = b[4:0];
        return x ^ (x >> 1);
    endfunction

    function automatic bit m_full();
        return m_lvl == 16;
    endfunction

    task automatic chk_regs(input string tag);
        chk({tag, ".wptr"}, 32'(wptr), 32'(gray(m_wr)));
        chk({tag, ".wlevel"}, 32'(wlevel), 32'(m_lvl));
        chk({tag, ".wfull"}, 32'(wfull), 32'(m_full()));
        chk({tag, ".wafull"}, 32'(walmost_full), 32'(m_lvl >= 12));
        chk({tag, ".wovf"}, 32'(woverflow), 32'(m_ovf));
        chk({tag, ".wdrop"}, 32'(wdrop_cnt), 32'(m_drop));
    endtask

    task automatic cycle(input string tag, input bit inc, input bit clr,
                         input int rd);
        bit full_now;
        @(negedge wclk);
        winc     = inc;
        wovf_clr = clr;
        m_rd     = rd;
        wq2_rptr = gray(rd);
        #1;
        full_now = m_full();
        chk({tag, ".wclken"}, 32'(wclken), 32'(inc & !full_now));
        chk({tag, ".waddr"}, 32'(waddr), 32'(m_wr % 16));
        @(posedge wclk);
        if (inc && !full_now) m_wr++;
        if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        if (inc && full_now) begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
        end
        m_lvl = (m_wr - m_rd) % 32;
        #1;
        chk_regs(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge wclk);
        winc     = 1'b0;
        wovf_clr = 1'b0;
        #2;
        wresetb = 1'b0;
        #1;
        m_wr = 0; m_rd = 0; m_lvl = 0; m_drop = 0; m_ovf = 1'b0;
        chk_regs(tag);
        chk({tag, ".waddr"}, 32'(waddr), 32'd0);
        chk({tag, ".wclken"}, 32'(wclken), 32'd0);
        wq2_rptr = 5'd0;
        @(negedge wclk);
        wresetb = 1'b1;
    endtask

    initial begin
        int rd;
        n_chk = 0; n_pass = 0;
        m_wr = 0; m_rd = 0; m_lvl = 0; m_drop = 0; m_ovf = 1'b0;
        winc = 1'b0; wovf_clr = 1'b0; wq2_rptr = 5'd0;
        wresetb = 1'b0;
        #3;
        chk_regs("rst");
        @(negedge wclk);
        wresetb = 1'b1;

        for (int i = 0; i < 16; i++) cycle("fill", 1'b1, 1'b0, 0);
        chk("fill.wptr_abs", 32'(wptr), 32'h18);
        chk("fill.full_abs", 32'(wfull), 32'd1);

        for (int i = 0; i < 3; i++) cycle("rej", 1'b1, 1'b0, 0);
        chk("rej.drop_abs", 32'(wdrop_cnt), 32'd3);
        cycle("clr", 1'b0, 1'b1, 0);

        cycle("drain", 1'b0, 1'b0, 16);
        chk("drain.lvl_abs", 32'(wlevel), 32'd0);
        for (int i = 0; i < 20; i++) cycle("wrap", 1'b1, 1'b0, 16);

        cycle("clrrej", 1'b1, 1'b1, 16);
        chk("clrrej.drop_abs", 32'(wdrop_cnt), 32'd1);

        for (int i = 0; i < 300; i++) cycle("sat", 1'b1, 1'b0, 16);
        chk("sat.drop_abs", 32'(wdrop_cnt), 32'd255);

        // Random traffic: synced read count lags the write count arbitrarily
        rd = 16;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) rd = rd + $urandom_range(0, m_wr - rd);
            cycle("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), rd);
        end

        for (int i = 0; i < 16; i++) cycle("refill", 1'b1, 1'b0, m_wr);
        for (int i = 0; i < 16; i++) cycle("refill2", 1'b1, 1'b0, rd);
        async_reset("midrst");
        for (int i = 0; i < 5; i++) cycle("post", 1'b1, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
